// File: rtl/mac_accumulator_if.sv
// Operand stream, result port and job control for mac_accumulator.
interface mac_accumulator_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 19,
  parameter int unsigned OUT_AW = 4
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [OUT_AW-1:0] res_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, a_data, b_data, res_ready,
    input  in_ready, res_valid, res_data, res_addr, busy, done
  );

  modport slave (
    input  start, in_valid, a_data, b_data, res_ready,
    output in_ready, res_valid, res_data, res_addr, busy, done
  );
endinterface

// File: rtl/mac_accumulator.sv
// Dot-product engine: K registered products per result, N_OUT results per job,
// results presented on a valid/ready port tagged with their element index.
module mac_accumulator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 8,
  parameter int unsigned N_OUT  = 16,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(K),
  parameter int unsigned OUT_AW = $clog2(N_OUT)
) (
  input logic               clk,
  input logic               rst,
  mac_accumulator_if.slave  bus
);

  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_cnt_q, k_cnt_d;
  logic [OUT_AW-1:0] elem_cnt_q, elem_cnt_d;
  logic [OUT_AW-1:0] out_cnt_q, out_cnt_d;
  logic [PW-1:0]     p_q;
  logic              p_valid_q, p_last_q, p_first_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;
  logic [OUT_AW-1:0] res_addr_q, res_addr_d;
  logic              done_q;

  logic             in_ready, accept, k_last, elem_last, res_hs, final_hs;
  logic [ACC_W-1:0] sum;

  always_comb begin
    in_ready  = (state_q == StRun) && (!res_valid_q || bus.res_ready);
    accept    = bus.in_valid && in_ready;
    k_last    = (k_cnt_q == KW'(K - 1));
    elem_last = (elem_cnt_q == OUT_AW'(N_OUT - 1));
    res_hs    = res_valid_q && bus.res_ready;
    final_hs  = res_hs && (state_q == StFlush) && (res_addr_q == OUT_AW'(N_OUT - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (accept && k_last && elem_last) state_d = StFlush;
      StFlush: if (final_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Input-side counters track which operand is the last of the job.
  always_comb begin
    k_cnt_d    = k_cnt_q;
    elem_cnt_d = elem_cnt_q;
    if (accept) begin
      k_cnt_d = k_last ? '0 : k_cnt_q + KW'(1);
      if (k_last) elem_cnt_d = elem_last ? '0 : elem_cnt_q + OUT_AW'(1);
    end
  end

  always_comb begin
    sum         = (p_first_q ? '0 : acc_q) + ACC_W'(p_q);
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_addr_d  = res_addr_q;
    out_cnt_d   = out_cnt_q;
    if (res_hs) res_valid_d = 1'b0;
    // A completing product may load a new result in the handshake cycle.
    if (p_valid_q) begin
      acc_d = sum;
      if (p_last_q) begin
        acc_d       = '0;
        res_data_d  = sum;
        res_valid_d = 1'b1;
        res_addr_d  = out_cnt_q;
        out_cnt_d   = (out_cnt_q == OUT_AW'(N_OUT - 1)) ? '0 : out_cnt_q + OUT_AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      k_cnt_q     <= '0;
      elem_cnt_q  <= '0;
      out_cnt_q   <= '0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_first_q   <= 1'b0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      out_cnt_q   <= out_cnt_d;
      p_valid_q   <= accept;
      if (accept) begin
        p_q       <= PW'(bus.a_data) * PW'(bus.b_data);
        p_last_q  <= k_last;
        p_first_q <= (k_cnt_q == '0);
      end
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_addr_q  <= res_addr_d;
      done_q      <= final_hs;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_addr  = res_addr_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized bench for mac_accumulator; expected sums come from plain arithmetic
// over the operands the bench generates.
module tb_mac_accumulator;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned K      = 8;
  localparam int unsigned N_OUT  = 16;
  localparam int unsigned ACC_W  = 19;
  localparam int unsigned OUT_AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_AW(OUT_AW)) bus ();

  mac_accumulator #(
    .DATA_W(DATA_W), .K(K), .N_OUT(N_OUT), .ACC_W(ACC_W), .OUT_AW(OUT_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc      = 0;
  logic [ACC_W-1:0]  obs_data[$];
  logic [OUT_AW-1:0] obs_addr[$];
  int                obs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes seen at the negedge complete at the following posedge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.res_valid && bus.res_ready) begin
        obs_data.push_back(bus.res_data);
        obs_addr.push_back(bus.res_addr);
        obs_cyc.push_back(cyc);
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_addr.delete();
    obs_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.a_data = '0; bus.b_data = '0;
    bus.res_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    clear_obs();
  endtask

  task automatic start_job();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit rand_rr,
                           output int stalls);
    bit ok = 1'b0;
    stalls = 0;
    bus.in_valid = 1'b1; bus.a_data = a; bus.b_data = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else begin
        stalls++;
        tick();
        if (rand_rr) bus.res_ready = ($urandom_range(0, 3) != 0);
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_pair: in_ready never rose, got stalls=%0d required <200", stalls);
    end
    tick();
    bus.in_valid = 1'b0;
    if (rand_rr) bus.res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_results(input int n);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 300 && obs_data.size() < n; i++) tick();
    checks++;
    if (obs_data.size() < n) begin
      failures++;
      $display("FAIL wait_results: got %0d results required %0d", obs_data.size(), n);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [ACC_W+OUT_AW+3:0] v;
    v = {bus.in_ready, bus.res_valid, bus.res_data, bus.res_addr, bus.busy, bus.done};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL %s: outputs got 0x%0h required 0", name, v);
    end
  endtask

  task automatic test_reset();
    int st, exp_sum;
    logic [7:0] a, b;
    rst = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.a_data = '0; bus.b_data = '0;
    bus.res_ready = 1'b1;
    #1;
    check_outputs_zero("reset_initial");
    repeat (2) tick();
    rst = 1'b1;
    start_job();
    for (int i = 0; i < 3; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, st);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("reset_mid_job");
    tick();
    rst = 1'b1;
    clear_obs();
    start_job();
    exp_sum = 0;
    for (int i = 0; i < K; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp_sum += int'(a) * int'(b);
      send_pair(a, b, 1'b0, st);
    end
    wait_results(1);
    checks++;
    if (obs_addr[0] !== 4'd0 || obs_data[0] !== ACC_W'(exp_sum)) begin
      failures++;
      $display("FAIL reset_restart: got addr=%0d data=%0d required addr=0 data=%0d",
               obs_addr[0], obs_data[0], exp_sum);
    end
  endtask

  task automatic test_unit_sum();
    int st;
    reset_dut();
    start_job();
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL unit_start: busy/in_ready got %b required 11", {bus.busy, bus.in_ready});
    end
    for (int i = 0; i < K; i++) send_pair(8'd1, 8'd1, 1'b0, st);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL unit_latency_early: res_valid got %b required 0", bus.res_valid);
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== ACC_W'(K) || bus.res_addr !== 4'd0) begin
      failures++;
      $display("FAIL unit_sum: got valid=%b data=%0d addr=%0d required valid=1 data=%0d addr=0",
               bus.res_valid, bus.res_data, bus.res_addr, K);
    end
  endtask

  task automatic test_full_scale();
    int st, exp_sum;
    reset_dut();
    start_job();
    exp_sum = 0;
    for (int i = 0; i < K; i++) begin
      exp_sum += 255 * 255;
      send_pair(8'd255, 8'd255, 1'b0, st);
    end
    wait_results(1);
    checks++;
    if (obs_data[0] !== ACC_W'(exp_sum) || obs_addr[0] !== 4'd0) begin
      failures++;
      $display("FAIL full_scale: got data=%0d addr=%0d required data=%0d addr=0",
               obs_data[0], obs_addr[0], exp_sum);
    end
  endtask

  task automatic test_backpressure();
    int st, exp0, exp1;
    logic [7:0] a, b;
    reset_dut();
    start_job();
    bus.res_ready = 1'b0;
    exp0 = 0;
    for (int i = 0; i < K; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp0 += int'(a) * int'(b);
      send_pair(a, b, 1'b0, st);
    end
    // First pair of element 1 goes in while the result is still being formed.
    bus.in_valid = 1'b1; bus.a_data = 8'd2; bus.b_data = 8'd3;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 ||
          bus.res_data !== ACC_W'(exp0) || bus.res_addr !== 4'd0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b vld=%b data=%0d addr=%0d required 0 1 %0d 0",
                 i, bus.in_ready, bus.res_valid, bus.res_data, bus.res_addr, exp0);
      end
      tick();
    end
    bus.res_ready = 1'b1;
    exp1 = 2 * 3;
    for (int i = 1; i < K; i++) begin
      exp1 += 2 * 3;
      send_pair(8'd2, 8'd3, 1'b0, st);
    end
    wait_results(2);
    checks++;
    if (obs_data[0] !== ACC_W'(exp0) || obs_addr[0] !== 4'd0) begin
      failures++;
      $display("FAIL backpressure_first: got data=%0d addr=%0d required data=%0d addr=0",
               obs_data[0], obs_addr[0], exp0);
    end
    checks++;
    if (obs_data[1] !== ACC_W'(exp1) || obs_addr[1] !== 4'd1) begin
      failures++;
      $display("FAIL backpressure_next: got data=%0d addr=%0d required data=%0d addr=1",
               obs_data[1], obs_addr[1], exp1);
    end
  endtask

  task automatic test_back_to_back();
    int st, total_stalls;
    int exp_sum[3];
    logic [7:0] a, b;
    reset_dut();
    start_job();
    total_stalls = 0;
    for (int e = 0; e < 3; e++) begin
      exp_sum[e] = 0;
      for (int i = 0; i < K; i++) begin
        a = 8'($urandom); b = 8'($urandom);
        exp_sum[e] += int'(a) * int'(b);
        bus.in_valid = 1'b1;
        send_pair(a, b, 1'b0, st);
        total_stalls += st;
      end
    end
    checks++;
    if (total_stalls !== 0) begin
      failures++;
      $display("FAIL b2b_stalls: got %0d stall cycles required 0", total_stalls);
    end
    wait_results(3);
    for (int e = 0; e < 3; e++) begin
      checks++;
      if (obs_data[e] !== ACC_W'(exp_sum[e]) || obs_addr[e] !== OUT_AW'(e)) begin
        failures++;
        $display("FAIL b2b_result[%0d]: got data=%0d addr=%0d required data=%0d addr=%0d",
                 e, obs_data[e], obs_addr[e], exp_sum[e], e);
      end
    end
    for (int e = 1; e < 3; e++) begin
      checks++;
      if (obs_cyc[e] - obs_cyc[e-1] !== K) begin
        failures++;
        $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                 e, obs_cyc[e] - obs_cyc[e-1], K);
      end
    end
  endtask

  task automatic test_full_job();
    int st;
    bit seen;
    reset_dut();
    start_job();
    for (int j = 0; j < N_OUT; j++) begin
      for (int k = 0; k < K; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (j == 5 && k == 3) begin
          bus.start = 1'b1;
          tick();
          bus.start = 1'b0;
        end
        send_pair(8'(j), 8'd1, 1'b1, st);
      end
    end
    bus.res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL job_done: got done_seen=%b busy=%b required 1 0", seen, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL job_done_width: done got %b required 0 one cycle later", bus.done);
    end
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL job_idle: got busy=%b done_count=%0d required busy=0 done_count=1",
               bus.busy, done_cnt);
    end
    checks++;
    if (obs_data.size() !== N_OUT) begin
      failures++;
      $display("FAIL job_count: got %0d results required %0d", obs_data.size(), N_OUT);
    end
    for (int j = 0; j < N_OUT && j < obs_data.size(); j++) begin
      checks++;
      if (obs_data[j] !== ACC_W'(K * j) || obs_addr[j] !== OUT_AW'(j)) begin
        failures++;
        $display("FAIL job_result[%0d]: got data=%0d addr=%0d required data=%0d addr=%0d",
                 j, obs_data[j], obs_addr[j], K * j, j);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit_sum();
    test_full_scale();
    test_backpressure();
    test_back_to_back();
    test_full_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
